// File: rtl/ddr3_ui_pkg.sv
// Shared DDR3 user-interface constants, used by the responder and the page-transfer controller.
package ddr3_ui_pkg;

    localparam int unsigned APP_ADDR_W = 28;
    localparam int unsigned APP_DATA_W = 128;
    localparam int unsigned APP_CMD_W  = 3;

    localparam logic [APP_CMD_W-1:0] APP_CMD_WRITE = 3'd0;
    localparam logic [APP_CMD_W-1:0] APP_CMD_RD    = 3'd1;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR step, polynomial x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/ddr3_ui_fifo.sv
// Synchronous FIFO with full/empty flags; DEPTH must be a power of two (>= 2).
module ddr3_ui_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage is not reset; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ddr3_ui_responder.sv
// BRAM-backed stand-in for the DDR3 controller user interface.
// Optional DDR3_UI_STALL_EN: LFSR-driven ready throttling on app_rdy / app_wdf_rdy.
module ddr3_ui_responder
    import ddr3_ui_pkg::*;
#(
    parameter int unsigned MEM_ADDR_BITS  = 10,
    parameter int unsigned RD_LATENCY     = 4,
    parameter int unsigned CMD_FIFO_DEPTH = 4,
    parameter int unsigned WDF_FIFO_DEPTH = 4,
    parameter int unsigned CALIB_DELAY    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [APP_ADDR_W-1:0] app_addr,
    input  logic [APP_CMD_W-1:0]  app_cmd,
    input  logic                  app_en,
    output logic                  app_rdy,
    input  logic [APP_DATA_W-1:0] app_wdf_data,
    input  logic                  app_wdf_wren,
    input  logic                  app_wdf_end,
    output logic                  app_wdf_rdy,
    output logic [APP_DATA_W-1:0] app_rd_data,
    output logic                  app_rd_data_valid,
    output logic                  init_calib_complete,
    output logic                  protocol_err
);

    localparam int unsigned RAM_DEPTH = 1 << MEM_ADDR_BITS;
    localparam int unsigned CMD_W     = APP_CMD_W + MEM_ADDR_BITS;

    logic                     cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic [CMD_W-1:0]         cmd_din, cmd_head;
    logic [APP_CMD_W-1:0]     head_cmd;
    logic [MEM_ADDR_BITS-1:0] head_word;
    logic                     wdf_push, wdf_pop, wdf_full, wdf_empty;
    logic [APP_DATA_W-1:0]    wdf_head;
    logic                     stall_cmd, stall_wdf;
    logic                     ram_we, ram_re, bad_cmd, bad_beat;
    logic                     unused_addr;

    logic [7:0]               calib_cnt_q, calib_cnt_d;
    logic                     calib_q;
    logic                     protocol_err_q;
    logic [APP_DATA_W-1:0]    ram_q [RAM_DEPTH];
    logic [APP_DATA_W-1:0]    ram_rdata_q;
    logic [RD_LATENCY-1:0]    rd_vld_q;
    logic [APP_DATA_W-1:0]    pipe_data_q [RD_LATENCY-1:1];

    assign unused_addr = ^{app_addr[APP_ADDR_W-1:MEM_ADDR_BITS+3], app_addr[2:0]};

`ifdef DDR3_UI_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign stall_cmd = (lfsr_q[1:0] == 2'b00);
    assign stall_wdf = (lfsr_q[3:2] == 2'b00);
`else
    assign stall_cmd = 1'b0;
    assign stall_wdf = 1'b0;
`endif

    // Ready depends only on registered state, never on app_en / app_wdf_wren.
    assign app_rdy     = calib_q & ~cmd_full & ~stall_cmd;
    assign app_wdf_rdy = calib_q & ~wdf_full & ~stall_wdf;

    assign cmd_push = app_en & app_rdy;
    assign cmd_din  = {app_cmd, app_addr[MEM_ADDR_BITS+2:3]};
    assign wdf_push = app_wdf_wren & app_wdf_rdy;
    assign bad_beat = wdf_push & ~app_wdf_end;

    ddr3_ui_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (cmd_push),
        .data_i  (cmd_din),
        .pop_i   (cmd_pop),
        .data_o  (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty)
    );

    ddr3_ui_fifo #(
        .WIDTH (APP_DATA_W),
        .DEPTH (WDF_FIFO_DEPTH)
    ) u_wdf_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (wdf_push),
        .data_i  (app_wdf_data),
        .pop_i   (wdf_pop),
        .data_o  (wdf_head),
        .full_o  (wdf_full),
        .empty_o (wdf_empty)
    );

    assign head_cmd  = cmd_head[CMD_W-1 -: APP_CMD_W];
    assign head_word = cmd_head[MEM_ADDR_BITS-1:0];

    // In-order execution of the queue head; a write without data stalls everything behind it.
    always_comb begin
        cmd_pop = 1'b0;
        wdf_pop = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        bad_cmd = 1'b0;
        if (!rst && !cmd_empty) begin
            if (head_cmd == APP_CMD_RD) begin
                cmd_pop = 1'b1;
                ram_re  = 1'b1;
            end else if (head_cmd == APP_CMD_WRITE) begin
                if (!wdf_empty) begin
                    cmd_pop = 1'b1;
                    wdf_pop = 1'b1;
                    ram_we  = 1'b1;
                end
            end else begin
                cmd_pop = 1'b1;
                bad_cmd = 1'b1;
            end
        end
    end

    // Backing store survives reset.
    always_ff @(posedge clk) begin
        if (ram_we) ram_q[head_word] <= wdf_head;
        if (ram_re) ram_rdata_q <= ram_q[head_word];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= '0;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            rd_vld_q       <= {rd_vld_q[RD_LATENCY-2:0], ram_re};
            pipe_data_q[1] <= ram_rdata_q;
            for (int i = 2; i < int'(RD_LATENCY); i++) begin
                pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
    end

    assign app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
    assign app_rd_data       = pipe_data_q[RD_LATENCY-1];

    assign calib_cnt_d = (calib_cnt_q == 8'hFF) ? calib_cnt_q : calib_cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            calib_cnt_q    <= '0;
            calib_q        <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            calib_cnt_q    <= calib_cnt_d;
            calib_q        <= calib_q | (32'(calib_cnt_d) >= CALIB_DELAY);
            protocol_err_q <= protocol_err_q | bad_cmd | bad_beat;
        end
    end

    assign init_calib_complete = calib_q;
    assign protocol_err        = protocol_err_q;

endmodule

// File: tb/tb_ddr3_ui_responder.sv
// Directed self-checking bench for ddr3_ui_responder (default parameters).
module tb_ddr3_ui_responder;
    import ddr3_ui_pkg::*;

    localparam int RD_LAT = 4;
    localparam int CALIB  = 64;
    localparam int CMD_D  = 4;

    logic                  clk;
    logic                  rst;
    logic [APP_ADDR_W-1:0] app_addr;
    logic [APP_CMD_W-1:0]  app_cmd;
    logic                  app_en;
    logic                  app_rdy;
    logic [APP_DATA_W-1:0] app_wdf_data;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic                  app_wdf_rdy;
    logic [APP_DATA_W-1:0] app_rd_data;
    logic                  app_rd_data_valid;
    logic                  init_calib_complete;
    logic                  protocol_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_valid  = 0;
    int acc_cyc  = 0;
    logic [APP_DATA_W-1:0] rd_data_q [$];
    int                    rd_cyc_q  [$];

    ddr3_ui_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .init_calib_complete (init_calib_complete),
        .protocol_err        (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture returned read data away from the active edge.
    always @(negedge clk) begin
        if (app_rd_data_valid) begin
            rd_data_q.push_back(app_rd_data);
            rd_cyc_q.push_back(cyc);
            n_valid <= n_valid + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_cmd(input logic [2:0] c, input int word);
        int n = 0;
        app_en   = 1'b1;
        app_cmd  = c;
        app_addr = APP_ADDR_W'(word * 8);
        while (!app_rdy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!app_rdy) check("cmd_rdy_timeout", 128'(app_rdy), 128'(1));
        acc_cyc = cyc;
        @(negedge clk);
        app_en = 1'b0;
    endtask

    task automatic send_wdf(input logic [127:0] d, input logic e);
        int n = 0;
        app_wdf_wren = 1'b1;
        app_wdf_end  = e;
        app_wdf_data = d;
        while (!app_wdf_rdy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!app_wdf_rdy) check("wdf_rdy_timeout", 128'(app_wdf_rdy), 128'(1));
        @(negedge clk);
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
    endtask

    task automatic wait_reads(input int n);
        int k = 0;
        while (rd_data_q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("rd_count", 128'(rd_data_q.size()), 128'(n));
    endtask

    task automatic read_check(input string tag, input int w0, input int n, input logic [127:0] base);
        rd_data_q.delete();
        rd_cyc_q.delete();
        for (int i = 0; i < n; i++) send_cmd(APP_CMD_RD, w0 + i);
        wait_reads(n);
        for (int i = 0; i < n && i < rd_data_q.size(); i++) begin
            check(tag, rd_data_q[i], base + 128'(i));
        end
    endtask

    // Called on the negedge where rst was just dropped.
    task automatic wait_calib(input string tag);
        int t0    = cyc;
        int early = 0;
        int n     = 0;
        while (!init_calib_complete && n < 300) begin
            if (app_rdy || app_wdf_rdy) early++;
            @(negedge clk);
            n++;
        end
        check(tag, 128'(cyc - t0), 128'(CALIB));
        check("rdy_before_calib", 128'(early), 128'(0));
        check("rdy_at_calib", 128'(app_rdy), 128'(1));
    endtask

    initial begin
        int accepts;
        int nv;
        rst          = 1'b1;
        app_addr     = '0;
        app_cmd      = '0;
        app_en       = 1'b0;
        app_wdf_data = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        repeat (5) @(negedge clk);

        check("rst_app_rdy", 128'(app_rdy), 128'(0));
        check("rst_wdf_rdy", 128'(app_wdf_rdy), 128'(0));
        check("rst_rd_valid", 128'(app_rd_data_valid), 128'(0));
        check("rst_rd_data", app_rd_data, 128'(0));
        check("rst_calib", 128'(init_calib_complete), 128'(0));
        check("rst_perr", 128'(protocol_err), 128'(0));

        rst = 1'b0;
        wait_calib("calib_delay");

        // Full page: 256 bursts with data = index, then read back.
        for (int i = 0; i < 256; i++) begin
            send_wdf(128'(i), 1'b1);
            send_cmd(APP_CMD_WRITE, i);
        end
        read_check("page_data", 0, 256, 128'(0));
        if (rd_cyc_q.size() == 256) check("page_no_gaps", 128'(rd_cyc_q[255] - rd_cyc_q[0]), 128'(255));
        check("page_perr", 128'(protocol_err), 128'(0));

        // Single read latency with an empty queue.
        repeat (4) @(negedge clk);
        rd_data_q.delete();
        rd_cyc_q.delete();
        send_cmd(APP_CMD_RD, 2);
        wait_reads(1);
        if (rd_cyc_q.size() > 0) begin
            check("rd_latency", 128'(rd_cyc_q[0] - acc_cyc), 128'(1 + RD_LAT));
            check("rd_latency_data", rd_data_q[0], 128'(2));
        end

        // Stalled write head: queue fills after CMD_FIFO_DEPTH accepts.
        accepts  = 0;
        app_en   = 1'b1;
        app_cmd  = APP_CMD_WRITE;
        app_addr = APP_ADDR_W'(300 * 8);
        for (int k = 0; k < 10; k++) begin
            if (app_rdy) accepts++;
            @(negedge clk);
            app_addr = APP_ADDR_W'((300 + accepts) * 8);
        end
        app_en = 1'b0;
        check("fill_accepts", 128'(accepts), 128'(CMD_D));
        check("fill_rdy_low", 128'(app_rdy), 128'(0));
        for (int k = 0; k < 4; k++) send_wdf(128'(32'hA0 + k), 1'b1);
        read_check("late_data", 300, 4, 128'(32'hA0));

        // Data queued before its commands.
        for (int k = 0; k < 4; k++) send_wdf(128'(32'hB0 + k), 1'b1);
        check("wdf_full_rdy_low", 128'(app_wdf_rdy), 128'(0));
        for (int k = 0; k < 4; k++) send_cmd(APP_CMD_WRITE, 2 + k);
        read_check("early_data", 2, 4, 128'(32'hB0));

        // Illegal command: discarded, flags error, no read return.
        nv = n_valid;
        send_cmd(3'd3, 7);
        repeat (10) @(negedge clk);
        check("illegal_no_valid", 128'(n_valid), 128'(nv));
        check("illegal_perr", 128'(protocol_err), 128'(1));
        read_check("illegal_ram_kept", 7, 1, 128'(7));
        check("perr_sticky", 128'(protocol_err), 128'(1));

        // Reset with reads in flight.
        nv = n_valid;
        send_cmd(APP_CMD_RD, 10);
        send_cmd(APP_CMD_RD, 11);
        send_cmd(APP_CMD_RD, 12);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_calib("calib_after_rst");
        check("rst_drops_reads", 128'(n_valid), 128'(nv));
        check("rst_clears_perr", 128'(protocol_err), 128'(0));
        read_check("ram_retained", 10, 3, 128'(10));
        read_check("ram_retained_a0", 300, 1, 128'(32'hA0));

        // Beat with wren != end: stored anyway, error flagged.
        send_wdf(128'(32'hC5), 1'b0);
        repeat (2) @(negedge clk);
        check("wdf_end_perr", 128'(protocol_err), 128'(1));
        send_cmd(APP_CMD_WRITE, 20);
        read_check("wdf_end_data", 20, 1, 128'(32'hC5));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
